uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: the counterpart of `UART_Sender` in the peripheral block, consuming the serial line that a sender drives. It samples `UART_RX` at 16× the baud rate using the shared `brclk` from the baud-rate generator and recovers 8N1 frames, LSB first. Each byte is presented on `RX_DATA` with a one-cycle `RX_STATUS` strobe to the peripheral/CPU bus logic. It also flags framing errors.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Holds the receiver FSM state encoding and the oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // brclk ticks per bit
  localparam int         OVERSAMPLE  = 16;
  // tick count at the middle of the start bit
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  // tick count one full bit after the previous sample point
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line and the baud-rate
// clock into the sysclk domain. rx_s is the double-flopped line, tick is a
// one-cycle pulse on each rising edge of brclk.
module uart_rx_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic brclk,
  input  logic UART_RX,
  output logic rx_s,
  output logic tick
);

  logic [1:0] rx_sync_r;
  logic [2:0] br_sync_r;

  // Two-flop synchronizer for the serial line; idles high out of reset.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], UART_RX};
    end
  end

  // Three-flop chain on brclk; the first stage only absorbs metastability.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      br_sync_r <= 3'b000;
    end else begin
      br_sync_r <= {br_sync_r[1:0], brclk};
    end
  end

  assign rx_s = rx_sync_r[1];
  assign tick = br_sync_r[1] & ~br_sync_r[2];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive stage (LSB first).
// Default build receives 8N1 frames. Defining UART_RX_PARITY_EN switches to
// 8E1 frames: a parity bit follows the data and mismatches pulse PARITY_ERR
// alongside RX_STATUS (the byte is still delivered).
module uart_receiver #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 brclk,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_STATUS,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR
);

  import uart_pkg::*;

  localparam int                 CNT_W    = $clog2(OVERSAMPLE);
  localparam int                 IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   MID_CNT  = CNT_W'(MID_SAMPLE);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(LAST_SAMPLE);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t             AFTER_DATA = PARITY;
`else
  localparam state_t             AFTER_DATA = STOP;
`endif

  logic                 rx_s;
  logic                 tick;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] sh_r, sh_s;
  logic [DATA_BITS-1:0] data_r, data_s;
  logic                 status_r, status_s;
  logic                 ferr_r, ferr_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_mis_r, par_mis_s;
  logic                 perr_r, perr_s;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  uart_rx_sync u_sync (
    .sysclk  (sysclk),
    .reset   (reset),
    .brclk   (brclk),
    .UART_RX (UART_RX),
    .rx_s    (rx_s),
    .tick    (tick)
  );

  // Next-state, datapath and strobe decode for the frame FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    sh_s     = sh_r;
    data_s   = data_r;
    status_s = 1'b0;
    ferr_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_s = par_mis_r;
    perr_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          cnt_s   = '0;
          state_s = START;
`ifdef UART_RX_PARITY_EN
          par_mis_s = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_r == MID_CNT) begin
            if (!rx_s) begin
              cnt_s   = '0;
              idx_s   = '0;
              state_s = DATA;
            end else begin
              // Line bounced back high before mid start bit: treat as glitch.
              state_s = IDLE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            sh_s  = {rx_s, sh_r[DATA_BITS-1:1]};
            idx_s = idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              state_s = AFTER_DATA;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            par_mis_s = (rx_s != even_parity(sh_r));
            state_s   = STOP;
          end else begin
            state_s = PARITY;
          end
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            if (rx_s) begin
              data_s   = sh_r;
              status_s = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_s   = par_mis_r;
`endif
              state_s  = IDLE;
            end else begin
              ferr_s  = 1'b1;
              state_s = BREAK;
            end
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = STOP;
        end
      end
      BREAK: begin
        // A held-low line must not restart a frame until it returns high.
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, datapath and registered output strobes.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= '0;
      sh_r     <= '0;
      data_r   <= '0;
      status_r <= 1'b0;
      ferr_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_r <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      sh_r     <= sh_s;
      data_r   <= data_s;
      status_r <= status_s;
      ferr_r   <= ferr_s;
`ifdef UART_RX_PARITY_EN
      par_mis_r <= par_mis_s;
      perr_r    <= perr_s;
`endif
    end
  end

  assign RX_DATA   = data_r;
  assign RX_STATUS = status_r;
  assign FRAME_ERR = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = perr_r;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver. Each frame sender
// pushes the strobe it should cause; a monitor records every strobe the
// DUT produces and each scenario task compares the two queues.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_HALF = 5;
  localparam int BR_HALF  = 40;            // tick every 8 sysclk
  localparam int BIT_CYC  = 128;           // 16 ticks * 8 sysclk
  localparam int BIT_NS   = BIT_CYC * 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b0;
  logic       brclk   = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       FRAME_ERR;
  logic       PARITY_ERR;

  uart_receiver dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .brclk      (brclk),
    .UART_RX    (UART_RX),
    .RX_DATA    (RX_DATA),
    .RX_STATUS  (RX_STATUS),
    .FRAME_ERR  (FRAME_ERR),
    .PARITY_ERR (PARITY_ERR)
  );

  always #CLK_HALF sysclk = ~sysclk;
  always #BR_HALF  brclk  = ~brclk;

  typedef struct {
    logic       st;
    logic       fe;
    logic       pe;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_good = 8'h00;

  // Monitor: record every strobe cycle together with RX_DATA at that cycle.
  always @(negedge sysclk) begin
    ev_t o;
    cyc = cyc + 1;
    if (RX_STATUS || FRAME_ERR || PARITY_ERR) begin
      o.st  = RX_STATUS;
      o.fe  = FRAME_ERR;
      o.pe  = PARITY_ERR;
      o.d   = RX_DATA;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  // Drive one frame and push the strobe it should produce.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    ev_t e;
    e.st  = stop_bit;
    e.fe  = ~stop_bit;
    e.pe  = stop_bit & bad_par & PAR_EN;
    e.d   = stop_bit ? d : last_good;
    e.cyc = 0;
    exp_q.push_back(e);
    if (stop_bit) last_good = d;
    UART_RX = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      #BIT_NS;
    end
`ifdef UART_RX_PARITY_EN
    UART_RX = (^d) ^ bad_par;
    #BIT_NS;
`endif
    UART_RX = stop_bit;
    #BIT_NS;
  endtask

  // Bounded wait until the monitor holds as many strobes as are expected.
  task automatic wait_events();
    for (int i = 0; i < 4 * BIT_CYC && obs_q.size() < exp_q.size(); i++) @(negedge sysclk);
    repeat (BIT_CYC) @(negedge sysclk);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    UART_RX = 1'b1;
    repeat (20) @(negedge sysclk);
    checks++;
    if (RX_DATA !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", RX_DATA);
    end
    checks++;
    if ({RX_STATUS, FRAME_ERR, PARITY_ERR} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {RX_STATUS, FRAME_ERR, PARITY_ERR});
    end
    reset = 1'b1;
    repeat (2 * FRAME_BITS * BIT_CYC) @(negedge sysclk);
    checks++;
    if (obs_q.size() != 0 || RX_DATA !== 8'h00) begin
      errors++; $display("FAIL reset_idle: got %0d strobes data %h want 0 strobes data 00", obs_q.size(), RX_DATA);
      obs_q.delete();
    end
  endtask

  task automatic test_loopback();
    ev_t e, o;
    int  t0, lat, want;
    t0 = cyc;
    send_frame(8'b01001010, 1'b1, 1'b0);
    UART_RX = 1'b1;
    wait_events();
    want = (2 * FRAME_BITS - 1) * BIT_CYC / 2;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL loopback_event: got no strobe want data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ({o.st, o.fe, o.pe, o.d} !== {e.st, e.fe, e.pe, e.d}) begin
          errors++; $display("FAIL loopback_event: got st=%b fe=%b pe=%b d=%h want st=%b fe=%b pe=%b d=%h",
                             o.st, o.fe, o.pe, o.d, e.st, e.fe, e.pe, e.d);
        end
        lat = o.cyc - t0;
        checks++;
        if (lat < want - 20 || lat > want + 20) begin
          errors++; $display("FAIL loopback_latency: got %0d cycles want %0d +-20", lat, want);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL loopback_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (RX_DATA !== 8'h4A) begin
      errors++; $display("FAIL loopback_data: got %h want 4a", RX_DATA);
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int  cy[2];
    int  n;
    n = 0;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    UART_RX = 1'b1;
    wait_events();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_event: got no strobe want data %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if (n < 2) cy[n] = o.cyc;
        n++;
        if ({o.st, o.fe, o.pe, o.d} !== {e.st, e.fe, e.pe, e.d}) begin
          errors++; $display("FAIL b2b_event: got st=%b fe=%b pe=%b d=%h want st=%b fe=%b pe=%b d=%h",
                             o.st, o.fe, o.pe, o.d, e.st, e.fe, e.pe, e.d);
        end
      end
    end
    checks++;
    if (n != 2 || cy[1] - cy[0] < FRAME_BITS * BIT_CYC - 12 || cy[1] - cy[0] > FRAME_BITS * BIT_CYC + 12) begin
      errors++; $display("FAIL b2b_spacing: got %0d strobes spacing %0d want 2 spacing %0d +-12",
                         n, (n == 2) ? cy[1] - cy[0] : 0, FRAME_BITS * BIT_CYC);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL b2b_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (RX_DATA !== 8'hA3) begin
      errors++; $display("FAIL b2b_data: got %h want a3", RX_DATA);
    end
  endtask

  task automatic test_glitch();
    UART_RX = 1'b0;
    #(3 * 2 * BR_HALF);
    UART_RX = 1'b1;
    repeat (2 * FRAME_BITS * BIT_CYC) @(negedge sysclk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (RX_DATA !== last_good) begin
      errors++; $display("FAIL glitch_data: got %h want %h", RX_DATA, last_good);
    end
  endtask

  task automatic test_frame_error();
    ev_t e, o;
    logic [7:0] held;
    held = last_good;
    send_frame(8'hFF, 1'b0, 1'b0);
    #(3 * BIT_NS);
    UART_RX = 1'b1;
    #BIT_NS;
    checks++;
    if (RX_DATA !== held) begin
      errors++; $display("FAIL ferr_retain: got %h want %h", RX_DATA, held);
    end
    send_frame(8'h12, 1'b1, 1'b0);
    UART_RX = 1'b1;
    wait_events();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL ferr_event: got no strobe want st=%b fe=%b d=%h", e.st, e.fe, e.d);
      end else begin
        o = obs_q.pop_front();
        if ({o.st, o.fe, o.pe, o.d} !== {e.st, e.fe, e.pe, e.d}) begin
          errors++; $display("FAIL ferr_event: got st=%b fe=%b pe=%b d=%h want st=%b fe=%b pe=%b d=%h",
                             o.st, o.fe, o.pe, o.d, e.st, e.fe, e.pe, e.d);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL ferr_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (RX_DATA !== 8'h12) begin
      errors++; $display("FAIL ferr_next_data: got %h want 12", RX_DATA);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    ev_t e, o;
    send_frame(8'h07, 1'b1, 1'b1);
    UART_RX = 1'b1;
    wait_events();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL parity_event: got no strobe want st=1 pe=1 d=%h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ({o.st, o.fe, o.pe, o.d} !== {e.st, e.fe, e.pe, e.d}) begin
          errors++; $display("FAIL parity_event: got st=%b fe=%b pe=%b d=%h want st=%b fe=%b pe=%b d=%h",
                             o.st, o.fe, o.pe, o.d, e.st, e.fe, e.pe, e.d);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL parity_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    // Frame F0: line low for start + four zero bits, then high to the end.
    UART_RX = 1'b0;
    #(BIT_NS * 5 / 2);
    reset = 1'b0;
    #1;
    checks++;
    if ({RX_DATA, RX_STATUS, FRAME_ERR, PARITY_ERR} !== 11'h000) begin
      errors++; $display("FAIL midreset_clear: got data %h strobes %b want 00 000",
                         RX_DATA, {RX_STATUS, FRAME_ERR, PARITY_ERR});
    end
    #(BIT_NS * 5 / 2 - 1);
    UART_RX = 1'b1;
    #(BIT_NS / 2);
    reset = 1'b1;
    last_good = 8'h00;
    repeat (2 * FRAME_BITS * BIT_CYC) @(negedge sysclk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL midreset_strobe: got %0d strobes want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (RX_DATA !== 8'h00) begin
      errors++; $display("FAIL midreset_data: got %h want 00", RX_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_error();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
